// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by the host arbiter and its bench.
package tlul_pkg;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb.sv
// Round-robin TL-UL host arbiter with in-order D-channel routing back to the issuing host.
// Optional d_source checking is enabled by defining TLUL_ARB_SRC_CHECK_EN.
module tlul_host_arb #(
   parameter int NumHosts       = 4,
   parameter int MaxOutstanding = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  tlul_pkg::tl_h2d_t [NumHosts-1:0]    tl_h_i,
   output tlul_pkg::tl_d2h_t [NumHosts-1:0]    tl_h_o,
   output tlul_pkg::tl_h2d_t                   tl_d_o,
   input  tlul_pkg::tl_d2h_t                   tl_d_i
`ifdef TLUL_ARB_SRC_CHECK_EN
   ,
   output logic                                src_err_o
`endif
);

   localparam int IdxW = $clog2(NumHosts);
   localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW = $clog2(MaxOutstanding + 1);

   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0] grant_idx_q, grant_idx_d;
   logic            grant_lock_q, grant_lock_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0] fifo_idx_q [MaxOutstanding];

   logic [IdxW-1:0] arb_idx, grant_idx, head;
   logic            full, nonempty, dev_a_valid, dev_d_ready, accept, pop;

   // First requesting host at or after rr_ptr, wrapping at NumHosts.
   always_comb begin
      logic            found;
      logic [IdxW:0]   cand;
      arb_idx = rr_ptr_q;
      found   = 1'b0;
      for (int k = 0; k < NumHosts; k++) begin
         cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
         if (cand >= (IdxW+1)'(NumHosts)) cand = cand - (IdxW+1)'(NumHosts);
         if (!found && tl_h_i[cand[IdxW-1:0]].a_valid) begin
            found   = 1'b1;
            arb_idx = cand[IdxW-1:0];
         end
      end
   end

   assign grant_idx   = grant_lock_q ? grant_idx_q : arb_idx;
   assign head        = fifo_idx_q[rd_ptr_q];
   assign full        = (cnt_q == CntW'(MaxOutstanding));
   assign nonempty    = (cnt_q != '0);
   assign dev_a_valid = rst_ni & tl_h_i[grant_idx].a_valid & ~full;
   assign accept      = dev_a_valid & tl_d_i.a_ready;
   assign dev_d_ready = rst_ni & nonempty & tl_h_i[head].d_ready;
   assign pop         = tl_d_i.d_valid & dev_d_ready;

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      grant_lock_d = grant_lock_q;
      grant_idx_d  = grant_idx;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      if (accept) begin
         rr_ptr_d     = (grant_idx == IdxW'(NumHosts - 1)) ? '0 : grant_idx + 1'b1;
         grant_lock_d = 1'b0;
         wr_ptr_d     = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      end else if (dev_a_valid) begin
         grant_lock_d = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({accept, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr_q     <= '0;
         grant_idx_q  <= '0;
         grant_lock_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         grant_idx_q  <= grant_idx_d;
         grant_lock_q <= grant_lock_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) fifo_idx_q[wr_ptr_q] <= grant_idx;
   end

`ifdef TLUL_ARB_SRC_CHECK_EN
   logic [7:0] fifo_src_q [MaxOutstanding];

   always_ff @(posedge clk_i) begin
      if (accept) fifo_src_q[wr_ptr_q] <= tl_h_i[grant_idx].a_source;
   end

   assign src_err_o = pop & (tl_d_i.d_source != fifo_src_q[rd_ptr_q]);
`endif

   // Only the granted host sees a_ready; only the FIFO head host sees D traffic.
   always_comb begin
      tl_h_o = '0;
      tl_d_o = '0;
      if (rst_ni) begin
         tl_d_o                    = tl_h_i[grant_idx];
         tl_d_o.a_valid            = dev_a_valid;
         tl_d_o.d_ready            = dev_d_ready;
         tl_h_o[head]              = tl_d_i;
         tl_h_o[head].a_ready      = 1'b0;
         tl_h_o[head].d_valid      = tl_d_i.d_valid & nonempty;
         tl_h_o[grant_idx].a_ready = tl_d_i.a_ready & ~full;
      end
   end

endmodule

// File: tb/tb_tlul_host_arb.sv
// Randomized scoreboard bench for tlul_host_arb: bench-side hosts and device, queue-based reference model.
module tb_tlul_host_arb;
   import tlul_pkg::*;

   localparam int NH    = 4;
   localparam int MAXO  = 4;
   localparam int NCYC  = 1600;
   localparam int DRAIN = 60;

   logic                  clk = 1'b0;
   logic                  rst_n;
   tl_h2d_t [NH-1:0]      tl_h_i;
   tl_d2h_t [NH-1:0]      tl_h_o;
   tl_h2d_t               tl_d_o;
   tl_d2h_t               tl_d_i;
`ifdef TLUL_ARB_SRC_CHECK_EN
   logic                  src_err;
`endif

   always #5 clk = ~clk;

   tlul_host_arb #(.NumHosts(NH), .MaxOutstanding(MAXO)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .tl_h_i (tl_h_i),
      .tl_h_o (tl_h_o),
      .tl_d_o (tl_d_o),
      .tl_d_i (tl_d_i)
`ifdef TLUL_ARB_SRC_CHECK_EN
      ,
      .src_err_o (src_err)
`endif
   );

   typedef struct {
      logic        v;
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  src;
   } req_t;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  src;
      logic        err;
      logic        bad;
   } resp_t;

   req_t   req [NH];
   int     seq [NH];
   logic   hdr [NH];
   resp_t  exp_q [NH][$];
   resp_t  dev_q [$];
   logic   bad_q [$];
   int     out_q [$];
   int     rr, lock;
   int     checks, failures;
   int     p_req, p_ar, p_dv, p_dr;
   logic   dev_ar, dev_dv, line_dv;

   logic   m_acc, m_hold, m_pop, d_cap, d_pop;
   int     m_grant;
   logic [31:0] cap_addr, cap_data;
   logic [7:0]  cap_src;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Device response is an arithmetic function of the A beat it received.
   function automatic resp_t resp_of(input logic [31:0] addr, input logic [31:0] data,
                                     input logic [7:0] src, input logic bad);
      resp_t r;
      r.data = addr ^ {data[15:0], data[31:16]};
      r.src  = src ^ {7'd0, bad};
      r.err  = ^addr[3:0];
      r.bad  = bad;
      return r;
   endfunction

   task automatic new_req(input int h);
      req[h].v    = 1'b1;
      req[h].addr = $urandom;
      req[h].data = $urandom;
      req[h].src  = 8'((h << 5) | (seq[h] & 31));
      seq[h]++;
   endtask

   task automatic drive_inputs(input logic force_spurious);
      for (int h = 0; h < NH; h++) begin
         if (!req[h].v && $urandom_range(0, 99) < p_req) new_req(h);
         hdr[h] = ($urandom_range(0, 99) < p_dr);
         tl_h_i[h]           = '0;
         tl_h_i[h].a_valid   = req[h].v;
         tl_h_i[h].a_opcode  = 3'd4;
         tl_h_i[h].a_size    = 2'd2;
         tl_h_i[h].a_source  = req[h].src;
         tl_h_i[h].a_address = req[h].addr;
         tl_h_i[h].a_mask    = 4'hf;
         tl_h_i[h].a_data    = req[h].data;
         tl_h_i[h].d_ready   = hdr[h];
      end
      dev_ar = ($urandom_range(0, 99) < p_ar);
      if (!dev_dv && dev_q.size() > 0 && $urandom_range(0, 99) < p_dv) dev_dv = 1'b1;
      tl_d_i         = '0;
      tl_d_i.a_ready = dev_ar;
      line_dv        = 1'b0;
      if (dev_dv) begin
         line_dv         = 1'b1;
         tl_d_i.d_opcode = 3'd1;
         tl_d_i.d_size   = 2'd2;
         tl_d_i.d_source = dev_q[0].src;
         tl_d_i.d_data   = dev_q[0].data;
         tl_d_i.d_error  = dev_q[0].err;
      end else if (dev_q.size() == 0 && (force_spurious || $urandom_range(0, 7) == 0)) begin
         line_dv         = 1'b1;
         tl_d_i.d_opcode = 3'd1;
         tl_d_i.d_source = 8'($urandom);
         tl_d_i.d_data   = $urandom;
      end
      tl_d_i.d_valid = line_dv;
   endtask

   task automatic check_and_decide();
      int   grant;
      int   head;
      logic full, exp_av, exp_dr;
      grant = -1;
      if (lock >= 0) grant = lock;
      else begin
         for (int k = 0; k < NH; k++) begin
            if (grant < 0 && req[(rr + k) % NH].v) grant = (rr + k) % NH;
         end
      end
      full   = (out_q.size() >= MAXO);
      exp_av = (grant >= 0) && !full;
      chk("dev_a_valid", 32'(tl_d_o.a_valid), 32'(exp_av));
      if (exp_av) begin
         chk("dev_a_source", 32'(tl_d_o.a_source), 32'(req[grant].src));
         chk("dev_a_address", tl_d_o.a_address, req[grant].addr);
      end
      if (grant >= 0) begin
         for (int h = 0; h < NH; h++)
            chk("host_a_ready", 32'(tl_h_o[h].a_ready), 32'((h == grant) && dev_ar && !full));
      end
      head   = (out_q.size() > 0) ? out_q[0] : -1;
      exp_dr = (head >= 0) && hdr[head];
      chk("dev_d_ready", 32'(tl_d_o.d_ready), 32'(exp_dr));
      for (int h = 0; h < NH; h++)
         chk("host_d_valid", 32'(tl_h_o[h].d_valid), 32'((h == head) && line_dv));
`ifdef TLUL_ARB_SRC_CHECK_EN
      chk("src_err", 32'(src_err), 32'(dev_dv && exp_dr && dev_q[0].bad));
`endif
      m_acc   = exp_av && dev_ar;
      m_hold  = exp_av && !dev_ar;
      m_grant = grant;
      m_pop   = dev_dv && exp_dr;
      d_cap   = tl_d_o.a_valid && dev_ar;
      d_pop   = dev_dv && tl_d_o.d_ready;
      cap_addr = tl_d_o.a_address;
      cap_data = tl_d_o.a_data;
      cap_src  = tl_d_o.a_source;
   endtask

   task automatic apply();
      logic b;
      if (d_pop) begin
         dev_q.delete(0);
         dev_dv = 1'b0;
      end
      if (m_acc) begin
`ifdef TLUL_ARB_SRC_CHECK_EN
         b = ($urandom_range(0, 3) == 0);
`else
         b = 1'b0;
`endif
         exp_q[m_grant].push_back(resp_of(req[m_grant].addr, req[m_grant].data, req[m_grant].src, b));
         bad_q.push_back(b);
         out_q.push_back(m_grant);
         rr   = (m_grant + 1) % NH;
         lock = -1;
         req[m_grant].v = 1'b0;
      end else if (m_hold) begin
         lock = m_grant;
      end
      if (m_pop) out_q.delete(0);
      if (d_cap) begin
         b = (bad_q.size() > 0) ? bad_q.pop_front() : 1'b0;
         dev_q.push_back(resp_of(cap_addr, cap_data, cap_src, b));
      end
   endtask

   // Monitor: every D handshake delivered to a host is checked against that host's queue.
   always @(negedge clk) begin
      resp_t e;
      if (rst_n === 1'b1) begin
         for (int h = 0; h < NH; h++) begin
            if (tl_h_o[h].d_valid && tl_h_i[h].d_ready) begin
               if (exp_q[h].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_resp host=%0d actual=d_valid required=none (t=%0t)", h, $time);
               end else begin
                  e = exp_q[h].pop_front();
                  chk("resp_data", tl_h_o[h].d_data, e.data);
                  chk("resp_source", 32'(tl_h_o[h].d_source), 32'(e.src));
                  chk("resp_error", 32'(tl_h_o[h].d_error), 32'(e.err));
                  $display("resp host=%0d src=%02h data=%08h", h, tl_h_o[h].d_source, tl_h_o[h].d_data);
               end
            end
         end
      end
   end

   initial begin
      checks = 0; failures = 0;
      rr = 0; lock = -1;
      dev_dv = 1'b0; line_dv = 1'b0; dev_ar = 1'b0;
      m_acc = 0; m_hold = 0; m_pop = 0; d_cap = 0; d_pop = 0; m_grant = 0;
      cap_addr = '0; cap_data = '0; cap_src = '0;
      for (int h = 0; h < NH; h++) begin
         seq[h] = 0;
         req[h].v = 1'b0;
         new_req(h);
      end
      rst_n = 1'b0;
      p_req = 100; p_ar = 100; p_dv = 100; p_dr = 100;
      drive_inputs(1'b1);
      @(posedge clk); #1;
      repeat (3) begin
         drive_inputs(1'b1);
         #3;
         chk("rst_dev_a_valid", 32'(tl_d_o.a_valid), 32'd0);
         chk("rst_dev_d_ready", 32'(tl_d_o.d_ready), 32'd0);
         for (int h = 0; h < NH; h++) begin
            chk("rst_host_a_ready", 32'(tl_h_o[h].a_ready), 32'd0);
            chk("rst_host_d_valid", 32'(tl_h_o[h].d_valid), 32'd0);
         end
`ifdef TLUL_ARB_SRC_CHECK_EN
         chk("rst_src_err", 32'(src_err), 32'd0);
`endif
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      for (int cyc = 0; cyc < NCYC + DRAIN; cyc++) begin
         if (cyc >= NCYC)      begin p_req = 0;  p_ar = 100; p_dv = 100; p_dr = 100; end
         else if (cyc < 400)   begin p_req = 90; p_ar = 80;  p_dv = 80;  p_dr = 80;  end
         else if (cyc < 800)   begin p_req = 90; p_ar = 25;  p_dv = 70;  p_dr = 70;  end
         else if (cyc < 1200)  begin p_req = 90; p_ar = 90;  p_dv = 8;   p_dr = 60;  end
         else                  begin p_req = 60; p_ar = 70;  p_dv = 85;  p_dr = 25;  end
         drive_inputs(1'b0);
         #3;
         check_and_decide();
         @(posedge clk); #1;
         apply();
      end
      for (int h = 0; h < NH; h++)
         chk("exp_q_drained", 32'(exp_q[h].size()), 32'd0);
      chk("dev_q_drained", 32'(dev_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
